// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with a small receive FIFO and STBo/ACKo handshake.
// Optional define UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit.
module uart_rx_fifo #(
   parameter int PRESCALER  = 1155,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RXD,
   output logic                 STBo,
   output logic [DATA_BITS-1:0] DATo,
   output logic                 PERRo,
   output logic                 FERRo,
   input  logic                 ACKo,
   output logic                 OVRo,
   input  logic                 OVR_CLR
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int W  = DATA_BITS + 2;
   localparam logic [10:0] PS_TOP = 11'(PRESCALER - 1);
   localparam logic [10:0] PS_MID = 11'(PRESCALER / 2 - 1);
   localparam logic [AW:0] FULLC  = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP, WAIT_HIGH
   } state_t;

   logic [2:0]           sync;
   logic                 rxdc;
   logic [10:0]          ps;
   logic                 smpl;
   logic                 bitv;
   state_t               st;
   logic [3:0]           cnt;
   logic [1:0]           scnt;
   logic [DATA_BITS-1:0] data;
   logic                 perr;
   logic                 ferr;
   logic [W-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]        rd;
   logic [AW-1:0]        wr;
   logic [AW:0]          count;
   logic [W-1:0]         head;
   logic                 load;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 wr_en;
   logic                 ferr_n;

   assign rxdc   = sync[2];
   assign load   = (st == IDLE) && !rxdc;
   assign ferr_n = ferr | ~bitv;
   assign push   = (st == STOP) && smpl && (scnt == 2'(STOP_BITS - 1));
   assign full   = (count == FULLC);
   assign pop    = STBo & ACKo;
   assign wr_en  = push && (!full || pop);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync <= 3'b111;
      else     sync <= {sync[1:0], RXD};
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic v1, v2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1   <= 1'b1;
         v2   <= 1'b1;
         bitv <= 1'b1;
      end else begin
         if (ps == 11'd2) v2 <= rxdc;
         if (ps == 11'd1) v1 <= rxdc;
         if (ps == '0)    bitv <= (v2 & v1) | (v2 & rxdc) | (v1 & rxdc);
      end
   end
`else
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            bitv <= 1'b1;
      else if (ps == '0)  bitv <= rxdc;
   end
`endif

   // The IDLE reload must not let a stale PS==0 fire a sample in START.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ps   <= PS_TOP;
         smpl <= 1'b0;
      end else begin
         if (load)           ps <= PS_MID;
         else if (ps == '0)  ps <= PS_TOP;
         else                ps <= ps - 11'd1;
         smpl <= (ps == '0) && !load;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st   <= IDLE;
         cnt  <= '0;
         scnt <= '0;
         data <= '0;
         perr <= 1'b0;
         ferr <= 1'b0;
      end else begin
         case (st)
            IDLE: if (!rxdc) st <= START;
            START: if (smpl) begin
               if (!bitv) begin
                  st   <= DATA;
                  cnt  <= '0;
                  scnt <= '0;
                  perr <= 1'b0;
                  ferr <= 1'b0;
               end else begin
                  st <= IDLE;
               end
            end
            DATA: if (smpl) begin
               data <= {bitv, data[DATA_BITS-1:1]};
               if (cnt == 4'(DATA_BITS - 1))
                  st <= (PARITY != 0) ? PAR : STOP;
               else
                  cnt <= cnt + 4'd1;
            end
            PAR: if (smpl) begin
               perr <= ((^data) ^ bitv) != (PARITY == 1);
               st   <= STOP;
            end
            STOP: if (smpl) begin
               ferr <= ferr_n;
               if (scnt == 2'(STOP_BITS - 1))
                  st <= ferr_n ? WAIT_HIGH : IDLE;
               else
                  scnt <= scnt + 2'd1;
            end
            WAIT_HIGH: if (rxdc) st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   // When full, a simultaneous pop frees the head slot that wr points at.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr] <= {ferr_n, perr, data};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
         OVRo  <= 1'b0;
      end else begin
         if (wr_en) wr <= wr + 1'b1;
         if (pop)   rd <= rd + 1'b1;
         count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
         OVRo  <= (push && full && !pop) || (OVRo && !OVR_CLR);
      end
   end

   assign head  = mem[rd];
   assign STBo  = (count != '0);
   assign DATo  = STBo ? head[DATA_BITS-1:0] : '0;
   assign PERRo = STBo & head[DATA_BITS];
   assign FERRo = STBo & head[DATA_BITS+1];

endmodule
